adc_frame_sequencer: RTL and testbench

ADC_FRAME_SEQUENCER -- requirements
Module: adc_frame_sequencer

---
 rtl/adc_seq_pkg.sv | 27 ++
 rtl/adc_frame_buffer.sv | 60 ++++++
 rtl/adc_frame_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_adc_frame_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_seq_pkg.sv
// ---------------------------------------------------------------------------
// adc_seq_pkg
// Shared definitions for the ADC frame sequencer: channel count, sample and
// frame-counter widths, FSM state codes and a small helper that isolates the
// lowest enabled channel of a mask.
// ---------------------------------------------------------------------------
package adc_seq_pkg;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 32;

  // State codes are visible on the 'state' output, so the values are fixed.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_COLLECT = 2'd2;
  localparam logic [1:0] ST_COMMIT  = 2'd3;

  // One sample per channel, channel 0 in the least significant slot.
  typedef logic [NUM_CH-1:0][DATA_W-1:0] frame_t;

  // One-hot of the lowest set bit (two's-complement trick); zero in -> zero out.
  function automatic logic [NUM_CH-1:0] lowest_set(input logic [NUM_CH-1:0] m);
    return m & (-m);
  endfunction

endpackage

// File: rtl/adc_frame_buffer.sv
// ---------------------------------------------------------------------------
// adc_frame_buffer
// Per-channel staging, pending and published sample registers.
//   clk, rst        : clock and synchronous active-high reset (clears all)
//   stage_we        : per-channel write strobe into staging
//   stage_din       : incoming channel samples
//   pend_load       : copy staging into the pending buffer
//   pub_en          : publish this cycle
//   pub_from_pend   : publish source select (1 = pending, 0 = staging)
//   pub_mask        : channels that take the new value on publish
//   frame_out       : published frame
// ---------------------------------------------------------------------------
module adc_frame_buffer
  import adc_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] stage_we,
  input  frame_t            stage_din,
  input  logic              pend_load,
  input  logic              pub_en,
  input  logic              pub_from_pend,
  input  logic [NUM_CH-1:0] pub_mask,
  output frame_t            frame_out
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DATA_W-1:0] stage_q, stage_d;
      logic [DATA_W-1:0] pend_q,  pend_d;
      logic [DATA_W-1:0] pub_q,   pub_d;

      always_comb begin
        stage_d = stage_we[gi] ? stage_din[gi] : stage_q;
        pend_d  = pend_load ? stage_q : pend_q;
        pub_d   = pub_q;
        // Channels outside the active mask keep their last published value.
        if (pub_en && pub_mask[gi]) begin
          pub_d = pub_from_pend ? pend_q : stage_q;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          stage_q <= '0;
          pend_q  <= '0;
          pub_q   <= '0;
        end else begin
          stage_q <= stage_d;
          pend_q  <= pend_d;
          pub_q   <= pub_d;
        end
      end

      assign frame_out[gi] = pub_q;
    end
  endgenerate

endmodule

// File: rtl/adc_frame_sequencer.sv
// ---------------------------------------------------------------------------
// adc_frame_sequencer
// Enables the sigma-delta channels, discards the first SETTLE_FRAMES frames
// while the decimators fill, then gathers one result per enabled channel into
// a coherent frame and publishes it, deferring publication while the SPI side
// holds rd_lock.
//   clk, rst            : 50 MHz clock, synchronous active-high reset
//   run                 : level request to operate
//   ch_mask             : enabled channels, latched when leaving IDLE
//   adc_ch0..3, adc_valid : channel results and one-cycle strobes
//   rd_lock             : freeze the published frame while high
//   clr_flags           : clear sticky flags (a same-cycle set wins)
//   adc_enable          : channel enable, high in every state except IDLE
//   frame_ch0..3        : published frame
//   frame_cnt           : number of published frames (wrapping)
//   frame_ready         : one-cycle pulse per publish
//   overrun             : sticky, a pending frame was replaced
//   timeout_fault       : sticky, a frame did not complete in time
//   state               : FSM state code
// ---------------------------------------------------------------------------
module adc_frame_sequencer
  import adc_seq_pkg::*;
#(
  parameter int SETTLE_FRAMES = 3,
  parameter int TIMEOUT_CYC   = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [DATA_W-1:0] adc_ch0,
  input  logic [DATA_W-1:0] adc_ch1,
  input  logic [DATA_W-1:0] adc_ch2,
  input  logic [DATA_W-1:0] adc_ch3,
  input  logic [NUM_CH-1:0] adc_valid,
  input  logic              rd_lock,
  input  logic              clr_flags,
  output logic              adc_enable,
  output logic [DATA_W-1:0] frame_ch0,
  output logic [DATA_W-1:0] frame_ch1,
  output logic [DATA_W-1:0] frame_ch2,
  output logic [DATA_W-1:0] frame_ch3,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              frame_ready,
  output logic              overrun,
  output logic              timeout_fault,
  output logic [1:0]        state
);

  localparam int SET_W = (SETTLE_FRAMES > 2) ? $clog2(SETTLE_FRAMES) : 1;
  localparam int TIM_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST =
    SET_W'((SETTLE_FRAMES > 0) ? SETTLE_FRAMES - 1 : 0);
  localparam logic [TIM_W-1:0] TIM_LAST =
    TIM_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  logic [1:0]        state_q,       state_d;
  logic [NUM_CH-1:0] mask_q,        mask_d;
  logic [NUM_CH-1:0] got_q,         got_d;
  logic [SET_W-1:0]  settle_cnt_q,  settle_cnt_d;
  logic [TIM_W-1:0]  timer_q,       timer_d;
  logic              pending_q,     pending_d;
  logic [CNT_W-1:0]  frame_cnt_q,   frame_cnt_d;
  logic              frame_ready_q, frame_ready_d;
  logic              overrun_q,     overrun_d;
  logic              timeout_q,     timeout_d;
  logic              adc_enable_q,  adc_enable_d;

  logic [NUM_CH-1:0] acc;
  logic [NUM_CH-1:0] got_all;
  logic [NUM_CH-1:0] stage_we;
  logic              pend_load;
  logic              pub_en;
  logic              pub_from_pend;
  logic              ovr_set;
  logic              tmo_set;
  frame_t            stage_din;
  frame_t            frame_out;

  assign acc     = adc_valid & mask_q;
  assign got_all = got_q | acc;

  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    got_d         = got_q;
    settle_cnt_d  = settle_cnt_q;
    timer_d       = timer_q;
    pending_d     = pending_q;
    frame_cnt_d   = frame_cnt_q;
    frame_ready_d = 1'b0;
    stage_we      = '0;
    pend_load     = 1'b0;
    pub_en        = 1'b0;
    pub_from_pend = 1'b0;
    ovr_set       = 1'b0;
    tmo_set       = 1'b0;

    if (state_q != ST_IDLE && !run) begin
      // Abandon whatever is in flight; published data and flags survive.
      state_d      = ST_IDLE;
      got_d        = '0;
      pending_d    = 1'b0;
      timer_d      = '0;
      settle_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run && ch_mask != '0) begin
            mask_d       = ch_mask;
            settle_cnt_d = '0;
            got_d        = '0;
            timer_d      = '0;
            state_d      = (SETTLE_FRAMES == 0) ? ST_COLLECT : ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          // One strobe of the lowest enabled channel marks one decimated frame.
          if ((adc_valid & lowest_set(mask_q)) != '0) begin
            if (settle_cnt_q == SETTLE_LAST) begin
              state_d = ST_COLLECT;
            end else begin
              settle_cnt_d = settle_cnt_q + SET_W'(1);
            end
          end
        end

        ST_COLLECT: begin
          stage_we = acc;
          if (got_all == mask_q) begin
            // Completion in the same cycle as the timeout deadline still counts.
            state_d = ST_COMMIT;
            got_d   = got_all;
            timer_d = '0;
          end else if (got_q != '0 && timer_q == TIM_LAST) begin
            tmo_set = 1'b1;
            got_d   = '0;
            timer_d = '0;
          end else begin
            got_d = got_all;
            // The timer only runs once the frame has its first strobe.
            if (got_q != '0) begin
              timer_d = timer_q + TIM_W'(1);
            end
          end
        end

        ST_COMMIT: begin
          state_d = ST_COLLECT;
          got_d   = '0;
          timer_d = '0;
          if (!rd_lock) begin
            // Fresh staging supersedes anything still pending.
            pub_en    = 1'b1;
            pending_d = 1'b0;
          end else begin
            pend_load = 1'b1;
            pending_d = 1'b1;
            if (pending_q) begin
              ovr_set = 1'b1;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase

      // Deferred publish once the reader lets go.
      if (state_q != ST_COMMIT && pending_q && !rd_lock) begin
        pub_en        = 1'b1;
        pub_from_pend = 1'b1;
        pending_d     = 1'b0;
      end
    end

    if (pub_en) begin
      frame_cnt_d   = frame_cnt_q + CNT_W'(1);
      frame_ready_d = 1'b1;
    end

    // Set beats clear when both happen in the same cycle.
    overrun_d    = ovr_set | (overrun_q & ~clr_flags);
    timeout_d    = tmo_set | (timeout_q & ~clr_flags);
    adc_enable_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      mask_q        <= '0;
      got_q         <= '0;
      settle_cnt_q  <= '0;
      timer_q       <= '0;
      pending_q     <= 1'b0;
      frame_cnt_q   <= '0;
      frame_ready_q <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
      adc_enable_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      got_q         <= got_d;
      settle_cnt_q  <= settle_cnt_d;
      timer_q       <= timer_d;
      pending_q     <= pending_d;
      frame_cnt_q   <= frame_cnt_d;
      frame_ready_q <= frame_ready_d;
      overrun_q     <= overrun_d;
      timeout_q     <= timeout_d;
      adc_enable_q  <= adc_enable_d;
    end
  end

  assign stage_din = {adc_ch3, adc_ch2, adc_ch1, adc_ch0};

  adc_frame_buffer u_buf (
    .clk           (clk),
    .rst           (rst),
    .stage_we      (stage_we),
    .stage_din     (stage_din),
    .pend_load     (pend_load),
    .pub_en        (pub_en),
    .pub_from_pend (pub_from_pend),
    .pub_mask      (mask_q),
    .frame_out     (frame_out)
  );

  assign frame_ch0     = frame_out[0];
  assign frame_ch1     = frame_out[1];
  assign frame_ch2     = frame_out[2];
  assign frame_ch3     = frame_out[3];
  assign frame_cnt     = frame_cnt_q;
  assign frame_ready   = frame_ready_q;
  assign overrun       = overrun_q;
  assign timeout_fault = timeout_q;
  assign adc_enable    = adc_enable_q;
  assign state         = state_q;

endmodule

// File: tb/tb_adc_frame_sequencer.sv
// Randomized frames against a frame-level reference model of the sequencer.
module tb_adc_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst, run, rd_lock, clr_flags;
  logic [3:0]  ch_mask, adc_valid;
  logic [15:0] adc_ch0, adc_ch1, adc_ch2, adc_ch3;
  logic        adc_enable, frame_ready, overrun, timeout_fault;
  logic [15:0] frame_ch0, frame_ch1, frame_ch2, frame_ch3;
  logic [31:0] frame_cnt;
  logic [1:0]  state;

  always #10 clk = ~clk;

  adc_frame_sequencer #(.SETTLE_FRAMES(3), .TIMEOUT_CYC(256)) dut (
    .clk(clk), .rst(rst), .run(run), .ch_mask(ch_mask),
    .adc_ch0(adc_ch0), .adc_ch1(adc_ch1), .adc_ch2(adc_ch2), .adc_ch3(adc_ch3),
    .adc_valid(adc_valid), .rd_lock(rd_lock), .clr_flags(clr_flags),
    .adc_enable(adc_enable),
    .frame_ch0(frame_ch0), .frame_ch1(frame_ch1), .frame_ch2(frame_ch2), .frame_ch3(frame_ch3),
    .frame_cnt(frame_cnt), .frame_ready(frame_ready), .overrun(overrun),
    .timeout_fault(timeout_fault), .state(state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int ready_seen = 0;

  // Reference model: published frame, counter, flags, pending copy.
  logic [15:0] m_frame [4];
  logic [15:0] m_pend_frame [4];
  logic        m_pend, m_ovr, m_tmo;
  logic [31:0] m_cnt;
  logic [3:0]  m_mask;

  always @(negedge clk) if (frame_ready === 1'b1) ready_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, "_ch0"}, frame_ch0, m_frame[0]);
    check({tag, "_ch1"}, frame_ch1, m_frame[1]);
    check({tag, "_ch2"}, frame_ch2, m_frame[2]);
    check({tag, "_ch3"}, frame_ch3, m_frame[3]);
    check({tag, "_cnt"}, frame_cnt, m_cnt);
    check({tag, "_ovr"}, overrun, m_ovr);
    check({tag, "_tmo"}, timeout_fault, m_tmo);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] v, input logic [3:0][15:0] d);
    adc_valid = v;
    adc_ch0 = d[0]; adc_ch1 = d[1]; adc_ch2 = d[2]; adc_ch3 = d[3];
    step();
    adc_valid = '0;
  endtask

  task automatic model_publish(input logic [3:0][15:0] d);
    for (int i = 0; i < 4; i++) if (m_mask[i]) m_frame[i] = d[i];
    m_cnt++;
  endtask

  task automatic clr_pulse();
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    m_ovr = 1'b0;
    m_tmo = 1'b0;
    check_all("clr");
  endtask

  task automatic set_lock(input bit v);
    logic [3:0][15:0] pd;
    rd_lock = v;
    step();
    if (!v && m_pend) begin
      for (int i = 0; i < 4; i++) pd[i] = m_pend_frame[i];
      model_publish(pd);
      m_pend = 1'b0;
      check("pend_ready", frame_ready, 1);
    end else begin
      check("lock_no_ready", frame_ready, 0);
    end
    check_all("lock");
  endtask

  // Called one cycle after the final strobe edge: the frame is in COMMIT.
  task automatic finish_frame(input bit lock, input logic [3:0][15:0] d);
    check("commit_state", state, 2'd3);
    check("commit_no_ready_yet", frame_ready, 0);
    step();
    if (!lock) begin
      model_publish(d);
      check("pub_ready", frame_ready, 1);
    end else begin
      if (m_pend) m_ovr = 1'b1;
      for (int i = 0; i < 4; i++) m_pend_frame[i] = d[i];
      m_pend = 1'b1;
      check("locked_no_ready", frame_ready, 0);
    end
    check_all("frame");
    check("back_to_collect", state, 2'd2);
    step();
    check("ready_one_cycle", frame_ready, 0);
    $display("frame mask=%h lock=%0d data=%h cnt=%0d pending=%0d", m_mask, lock, d, m_cnt, m_pend);
  endtask

  // Well-formed frame: every enabled channel strobes within a random span;
  // optional early junk strobes are later overwritten, masked-off channels
  // carry noise that must be ignored.
  task automatic do_frame(input bit lock, input bit junk, input int gap);
    logic [3:0][15:0] real_d, d;
    logic [3:0] v;
    int off [4];
    int span, last;
    repeat (gap) step();
    span = $urandom_range(1, 200);
    do last = $urandom_range(0, 3); while (!m_mask[last]);
    for (int i = 0; i < 4; i++) begin
      real_d[i] = 16'($urandom);
      if (i == last) off[i] = span;
      else off[i] = $urandom_range((junk && m_mask[i]) ? 1 : 0, span);
    end
    for (int t = 0; t <= span; t++) begin
      v = '0;
      d = '0;
      for (int i = 0; i < 4; i++) begin
        if (junk && t == 0 && m_mask[i] && i != last) begin
          v[i] = 1'b1; d[i] = ~real_d[i];
        end
        if (off[i] == t) begin
          v[i] = 1'b1; d[i] = m_mask[i] ? real_d[i] : 16'($urandom);
        end
      end
      if (v != '0) pulse(v, d); else step();
    end
    finish_frame(lock, real_d);
  endtask

  task automatic start_run(input logic [3:0] mask, input int gap);
    ch_mask = mask;
    run = 1'b1;
    step();
    m_mask = mask;
    check("settle_entry", state, 2'd1);
    check("enable_on", adc_enable, 1);
    for (int n = 0; n < 3; n++) begin
      repeat (gap) step();
      pulse(4'hF, {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)});
      check("settle_progress", state, (n == 2) ? 2'd2 : 2'd1);
    end
    check_all("settled");
  endtask

  task automatic stop_run();
    run = 1'b0;
    step();
    m_pend = 1'b0;
    check("stop_idle", state, 2'd0);
    check("stop_enable_off", adc_enable, 0);
    check_all("stop");
  endtask

  initial begin
    int r0;
    rst = 1'b1; run = 1'b0; rd_lock = 1'b0; clr_flags = 1'b0;
    ch_mask = '0; adc_valid = '0;
    adc_ch0 = '0; adc_ch1 = '0; adc_ch2 = '0; adc_ch3 = '0;
    for (int i = 0; i < 4; i++) begin m_frame[i] = '0; m_pend_frame[i] = '0; end
    m_pend = 0; m_ovr = 0; m_tmo = 0; m_cnt = 0; m_mask = 0;
    repeat (3) step();
    check("rst_state", state, 2'd0);
    check("rst_enable", adc_enable, 0);
    check("rst_ready", frame_ready, 0);
    check_all("rst");
    rst = 1'b0;
    step();

    // run with an empty mask is ignored
    run = 1'b1; ch_mask = 4'h0;
    repeat (2) step();
    check("empty_mask_idle", state, 2'd0);
    check("empty_mask_enable", adc_enable, 0);
    run = 1'b0;
    step();

    // first three frames discarded, fourth published
    start_run(4'hF, 1000);
    do_frame(1'b0, 1'b0, 1000);
    check("first_cnt", frame_cnt, 1);

    // partial mask keeps masked-off outputs
    stop_run();
    start_run(4'h5, 20);
    repeat (20) step();
    pulse(4'hF, {16'h5555, 16'hABCD, 16'h7777, 16'h1234});
    finish_frame(1'b0, {16'h0000, 16'hABCD, 16'h0000, 16'h1234});

    // timeout boundary, then clr_flags colliding with a timeout
    stop_run();
    start_run(4'hF, 20);
    clr_pulse();
    r0 = ready_seen;
    pulse(4'b0001, {16'h0, 16'h0, 16'h0, 16'h1111});
    repeat (255) step();
    check("tmo_not_yet", timeout_fault, 0);
    step();
    m_tmo = 1'b1;
    check("tmo_set", timeout_fault, 1);
    repeat (43) step();
    pulse(4'b1000, {16'h3333, 16'h0, 16'h0, 16'h0});
    repeat (9) step();
    clr_pulse();
    repeat (245) step();
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    m_tmo = 1'b1;
    check("tmo_beats_clr", timeout_fault, 1);
    check_all("tmo");
    check("tmo_no_publish", ready_seen - r0, 0);
    do_frame(1'b0, 1'b0, 20);

    // two frames while locked: overrun, single publish on release
    set_lock(1'b1);
    do_frame(1'b1, 1'b0, 10);
    do_frame(1'b1, 1'b1, 10);
    check("ovr_flag", overrun, 1);
    r0 = ready_seen;
    set_lock(1'b0);
    repeat (5) step();
    check("ovr_single_publish", ready_seen - r0, 1);

    // randomized sessions
    for (int s = 0; s < 3; s++) begin
      logic [3:0] mk;
      stop_run();
      mk = 4'($urandom_range(1, 15));
      start_run(mk, 10);
      for (int f = 0; f < 8; f++) begin
        bit lk;
        lk = ($urandom_range(0, 3) == 0);
        set_lock(lk);
        if ($urandom_range(0, 4) == 0) clr_pulse();
        do_frame(lk, 1'($urandom_range(0, 1)), 5);
      end
      set_lock(1'b0);
    end

    // run dropped mid-frame
    stop_run();
    start_run(4'hF, 10);
    repeat (5) step();
    r0 = ready_seen;
    pulse(4'b0011, {16'h0, 16'h0, 16'h2222, 16'h4444});
    repeat (3) step();
    stop_run();
    repeat (300) step();
    check("drop_no_publish", ready_seen - r0, 0);
    check_all("drop");
    start_run(4'hF, 10);
    do_frame(1'b0, 1'b0, 10);

    // reset mid-frame with a pending frame: nothing published, all cleared
    set_lock(1'b1);
    do_frame(1'b1, 1'b0, 10);
    pulse(4'b0001, {16'h0, 16'h0, 16'h0, 16'h9999});
    r0 = ready_seen;
    rst = 1'b1; run = 1'b0; rd_lock = 1'b0;
    step();
    for (int i = 0; i < 4; i++) m_frame[i] = '0;
    m_pend = 0; m_ovr = 0; m_tmo = 0; m_cnt = 0;
    check("rst2_state", state, 2'd0);
    check_all("rst2");
    rst = 1'b0;
    repeat (10) step();
    check("rst2_no_publish", ready_seen - r0, 0);
    check_all("post_rst2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
